// File: rtl/alu_input_sequencer.sv
// Operand/opcode entry sequencer for the board-level ALU: four debounced push-buttons
// walk an FSM that loads A, B and the opcode, then captures and shows the ALU result.
module alu_input_sequencer #(
  parameter int unsigned NB_OPERANDO = 8,
  parameter int unsigned NB_OPCODE   = 6,
  parameter int unsigned NB_OUT      = 8,
  parameter int unsigned N_DEBOUNCE  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [NB_OPERANDO-1:0] i_switch,
  input  logic                   i_boton_1,
  input  logic                   i_boton_2,
  input  logic                   i_boton_3,
  input  logic                   i_boton_4,
  input  logic [NB_OUT-1:0]      i_alu_result,
  output logic [NB_OPERANDO-1:0] o_dato_a,
  output logic [NB_OPERANDO-1:0] o_dato_b,
  output logic [NB_OPCODE-1:0]   o_opcode,
  output logic [NB_OUT-1:0]      o_result,
  output logic                   o_valid,
  output logic                   o_error,
  output logic [2:0]             o_state
);

  localparam int unsigned N_BTN  = 4;
  localparam int unsigned NB_CNT = $clog2(N_DEBOUNCE + 1);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // Button conditioning: 2-flop sync, level debounce, registered rising pulse
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0]  btn_raw;
  logic [N_BTN-1:0]  sync1_q, sync1_d;
  logic [N_BTN-1:0]  sync2_q, sync2_d;
  logic [N_BTN-1:0]  deb_q, deb_d;
  logic [N_BTN-1:0]  press_q, press_d;
  logic [NB_CNT-1:0] cnt_q [N_BTN];
  logic [NB_CNT-1:0] cnt_d [N_BTN];

  assign btn_raw = {i_boton_4, i_boton_3, i_boton_2, i_boton_1};

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    press_d = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      cnt_d[i] = '0;
      // counter only runs while the synced level disagrees with the debounced one
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == NB_CNT'(N_DEBOUNCE - 1)) begin
          deb_d[i]   = sync2_q[i];
          press_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + NB_CNT'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      press_q <= '0;
      for (int i = 0; i < int'(N_BTN); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      press_q <= press_d;
      for (int i = 0; i < int'(N_BTN); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Opcode legality
  // ---------------------------------------------------------------------------
  logic [NB_OPCODE-1:0] op_sw;
  logic                 op_legal;

  assign op_sw = i_switch[NB_OPCODE-1:0];

  always_comb begin
    op_legal = 1'b0;
    case (op_sw)
      NB_OPCODE'(6'b100000),
      NB_OPCODE'(6'b100010),
      NB_OPCODE'(6'b100100),
      NB_OPCODE'(6'b100101),
      NB_OPCODE'(6'b100110),
      NB_OPCODE'(6'b000011),
      NB_OPCODE'(6'b000010),
      NB_OPCODE'(6'b100111): op_legal = 1'b1;
      default:               op_legal = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Entry FSM
  // ---------------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic [NB_OPERANDO-1:0] dato_a_q, dato_a_d;
  logic [NB_OPERANDO-1:0] dato_b_q, dato_b_d;
  logic [NB_OPCODE-1:0]   opcode_q, opcode_d;
  logic [NB_OUT-1:0]      result_q, result_d;
  logic                   valid_q, valid_d;
  logic                   error_q, error_d;
  logic                   p1, p2, p3, p4;

  assign p1 = press_q[0];
  assign p2 = press_q[1];
  assign p3 = press_q[2];
  assign p4 = press_q[3];

  // Within each state the if/else order gives priority 1>2>3>4 among legal presses
  always_comb begin
    state_d  = state_q;
    dato_a_d = dato_a_q;
    dato_b_d = dato_b_q;
    opcode_d = opcode_q;
    result_d = result_q;
    valid_d  = valid_q;
    error_d  = error_q;
    case (state_q)
      S_A: begin
        if (p1) begin
          dato_a_d = i_switch;
          state_d  = S_B;
        end
      end
      S_B: begin
        if (p1) begin
          dato_a_d = i_switch;
        end else if (p2) begin
          dato_b_d = i_switch;
          state_d  = S_OP;
        end
      end
      S_OP: begin
        if (p1) begin
          dato_a_d = i_switch;
          error_d  = 1'b0;
          state_d  = S_B;
        end else if (p3) begin
          opcode_d = op_sw;
          if (op_legal) begin
            error_d = 1'b0;
            state_d = S_EXEC;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_EXEC: begin
        result_d = i_alu_result;
        valid_d  = 1'b1;
        state_d  = S_SHOW;
      end
      S_SHOW: begin
        if (p1) begin
          dato_a_d = i_switch;
          valid_d  = 1'b0;
          state_d  = S_B;
        end else if (p3) begin
          opcode_d = op_sw;
          valid_d  = 1'b0;
          if (op_legal) begin
            error_d = 1'b0;
            state_d = S_EXEC;
          end else begin
            error_d = 1'b1;
            state_d = S_OP;
          end
        end else if (p4) begin
          valid_d = 1'b0;
          state_d = S_OP;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_A;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= S_A;
      dato_a_q <= '0;
      dato_b_q <= '0;
      opcode_q <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dato_a_q <= dato_a_d;
      dato_b_q <= dato_b_d;
      opcode_q <= opcode_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  assign o_dato_a = dato_a_q;
  assign o_dato_b = dato_b_q;
  assign o_opcode = opcode_q;
  assign o_result = result_q;
  assign o_valid  = valid_q;
  assign o_error  = error_q;
  assign o_state  = state_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Bench for alu_input_sequencer: directed vector table, latency/bounce/reset sequences,
// then random button/switch traffic against a rule-level reference model.
module tb_alu_input_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] sw;
  logic [3:0] btn;
  logic [7:0] alu_res;
  logic [7:0] dato_a, dato_b, result;
  logic [5:0] opcode;
  logic       valid, error;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  alu_input_sequencer #(
    .NB_OPERANDO(8), .NB_OPCODE(6), .NB_OUT(8), .N_DEBOUNCE(4)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_switch(sw),
    .i_boton_1(btn[0]), .i_boton_2(btn[1]), .i_boton_3(btn[2]), .i_boton_4(btn[3]),
    .i_alu_result(alu_res),
    .o_dato_a(dato_a), .o_dato_b(dato_b), .o_opcode(opcode), .o_result(result),
    .o_valid(valid), .o_error(error), .o_state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'b100000: return a + b;
      6'b100010: return a - b;
      6'b100100: return a & b;
      6'b100101: return a | b;
      6'b100110: return a ^ b;
      6'b000011: return 8'($signed(a) >>> b);
      6'b000010: return a >> b;
      6'b100111: return ~(a | b);
      default:   return 8'h00;
    endcase
  endfunction

  assign alu_res = alu_f(dato_a, dato_b, opcode);

  // Reference model: operand registers plus a named phase, updated per press
  localparam int PH_A = 0, PH_B = 1, PH_OP = 2, PH_SHOW = 4;
  logic [7:0] m_a, m_b, m_res;
  logic [5:0] m_op;
  logic       m_valid, m_err;
  int         m_ph;
  logic [5:0] legal_ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27};

  function automatic bit is_legal(input logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_a = 0; m_b = 0; m_res = 0; m_op = 0; m_valid = 0; m_err = 0; m_ph = PH_A;
  endtask

  task automatic model_press(input logic [3:0] mask, input logic [7:0] s);
    bit run;
    run = 1'b0;
    if (m_ph == PH_A) begin
      if (mask[0]) begin m_a = s; m_ph = PH_B; end
    end else if (m_ph == PH_B) begin
      if (mask[0]) m_a = s;
      else if (mask[1]) begin m_b = s; m_ph = PH_OP; end
    end else if (m_ph == PH_OP) begin
      if (mask[0]) begin m_a = s; m_err = 0; m_ph = PH_B; end
      else if (mask[2]) begin
        m_op = s[5:0];
        m_err = !is_legal(m_op);
        run = !m_err;
      end
    end else begin
      if (mask[0]) begin m_a = s; m_valid = 0; m_ph = PH_B; end
      else if (mask[2]) begin
        m_op = s[5:0];
        m_valid = 0;
        m_err = !is_legal(m_op);
        if (m_err) m_ph = PH_OP; else run = 1'b1;
      end else if (mask[3]) begin m_valid = 0; m_ph = PH_OP; end
    end
    if (run) begin
      m_res = alu_f(m_a, m_b, m_op);
      m_valid = 1'b1;
      m_ph = PH_SHOW;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [5:0] op, input logic [7:0] res, input logic v,
                           input logic e, input logic [2:0] st);
    check({tag, ".a"},     32'(dato_a), 32'(a));
    check({tag, ".b"},     32'(dato_b), 32'(b));
    check({tag, ".op"},    32'(opcode), 32'(op));
    check({tag, ".res"},   32'(result), 32'(res));
    check({tag, ".valid"}, 32'(valid),  32'(v));
    check({tag, ".err"},   32'(error),  32'(e));
    check({tag, ".state"}, 32'(state),  32'(st));
  endtask

  // Clean press: hold past the action edge and a following exec, release, let it settle
  task automatic do_press(input logic [3:0] mask, input logic [7:0] s);
    @(negedge clk);
    sw = s; btn = mask;
    repeat (9) @(posedge clk);
    @(negedge clk);
    btn = 4'b0000;
    repeat (8) @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] btn;
    logic [7:0] sw;
    logic [7:0] a, b;
    logic [5:0] op;
    logic [7:0] res;
    logic       v, e;
    logic [2:0] st;
  } vec_t;

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{4'b0001, 8'hC0, 8'hC0, 8'h00, 6'h00, 8'h00, 1'b0, 1'b0, 3'd1};
    tbl[1]  = '{4'b0010, 8'h01, 8'hC0, 8'h01, 6'h00, 8'h00, 1'b0, 1'b0, 3'd2};
    tbl[2]  = '{4'b0100, 8'h20, 8'hC0, 8'h01, 6'h20, 8'hC1, 1'b1, 1'b0, 3'd4};
    tbl[3]  = '{4'b1000, 8'h22, 8'hC0, 8'h01, 6'h20, 8'hC1, 1'b0, 1'b0, 3'd2};
    tbl[4]  = '{4'b0100, 8'h22, 8'hC0, 8'h01, 6'h22, 8'hBF, 1'b1, 1'b0, 3'd4};
    tbl[5]  = '{4'b1000, 8'h00, 8'hC0, 8'h01, 6'h22, 8'hBF, 1'b0, 1'b0, 3'd2};
    tbl[6]  = '{4'b0100, 8'h00, 8'hC0, 8'h01, 6'h00, 8'hBF, 1'b0, 1'b1, 3'd2};
    tbl[7]  = '{4'b0100, 8'h24, 8'hC0, 8'h01, 6'h24, 8'h00, 1'b1, 1'b0, 3'd4};
    tbl[8]  = '{4'b0100, 8'h3F, 8'hC0, 8'h01, 6'h3F, 8'h00, 1'b0, 1'b1, 3'd2};
    tbl[9]  = '{4'b0001, 8'h5A, 8'h5A, 8'h01, 6'h3F, 8'h00, 1'b0, 1'b0, 3'd1};
    tbl[10] = '{4'b0100, 8'h25, 8'h5A, 8'h01, 6'h3F, 8'h00, 1'b0, 1'b0, 3'd1};
    tbl[11] = '{4'b0110, 8'h0F, 8'h5A, 8'h0F, 6'h3F, 8'h00, 1'b0, 1'b0, 3'd2};
    tbl[12] = '{4'b0110, 8'h26, 8'h5A, 8'h0F, 6'h26, 8'h55, 1'b1, 1'b0, 3'd4};
    tbl[13] = '{4'b0011, 8'h11, 8'h11, 8'h0F, 6'h26, 8'h55, 1'b0, 1'b0, 3'd1};
    tbl[14] = '{4'b0011, 8'h33, 8'h33, 8'h0F, 6'h26, 8'h55, 1'b0, 1'b0, 3'd1};
    tbl[15] = '{4'b1000, 8'h00, 8'h33, 8'h0F, 6'h26, 8'h55, 1'b0, 1'b0, 3'd1};

    rst_n = 1'b0; sw = 8'h00; btn = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 8'h00, 8'h00, 6'h00, 8'h00, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 16; i++) begin
      do_press(tbl[i].btn, tbl[i].sw);
      check_all($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].res,
                tbl[i].v, tbl[i].e, tbl[i].st);
    end

    // Bouncy boton_1: synced high runs of 3 never reach the debounce threshold
    @(negedge clk);
    sw = 8'hEE;
    for (int r = 0; r < 4; r++) begin
      btn = 4'b0001; repeat (3) @(negedge clk);
      btn = 4'b0000; @(negedge clk);
    end
    repeat (12) @(negedge clk);
    check("bounce.a", 32'(dato_a), 32'h33);
    check("bounce.state", 32'(state), 32'd1);

    // Clean hold: A loads on exactly the 7th edge after the first high sample
    btn = 4'b0001;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      if (e == 6) check("lat.a_e6", 32'(dato_a), 32'h33);
      if (e == 7) check("lat.a_e7", 32'(dato_a), 32'hEE);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    btn = 4'b0000;
    repeat (8) @(posedge clk);

    do_press(4'b0010, 8'h02);
    check_all("ldb", 8'hEE, 8'h02, 6'h26, 8'h55, 1'b0, 1'b0, 3'd2);
    do_press(4'b0100, 8'h20);
    check_all("exec", 8'hEE, 8'h02, 6'h20, 8'hF0, 1'b1, 1'b0, 3'd4);

    // Reset mid-show while boton_1 is held through reset release
    @(negedge clk);
    sw = 8'h77; btn = 4'b0001;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all("midrst", 8'h00, 8'h00, 6'h00, 8'h00, 1'b0, 1'b0, 3'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      if (e == 6) check("hold.a_e6", 32'(dato_a), 32'h00);
      if (e == 7) begin
        check("hold.a_e7", 32'(dato_a), 32'h77);
        check("hold.state_e7", 32'(state), 32'd1);
      end
    end
    @(negedge clk);
    sw = 8'h99;
    repeat (20) @(posedge clk);
    #1;
    check("norepeat.a", 32'(dato_a), 32'h77);
    check("norepeat.state", 32'(state), 32'd1);
    @(negedge clk);
    btn = 4'b0000;
    repeat (8) @(posedge clk);

    // Random traffic against the reference model
    model_reset();
    model_press(4'b0001, 8'h77);
    for (int i = 0; i < 40; i++) begin
      logic [3:0] mask;
      logic [7:0] s;
      mask = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 3) != 0) s = {2'($urandom), legal_ops[$urandom_range(0, 7)]};
      else s = 8'($urandom);
      do_press(mask, s);
      model_press(mask, s);
      check_all($sformatf("rnd%0d", i), m_a, m_b, m_op, m_res, m_valid, m_err, 3'(m_ph));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
